// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller of the light RV32I core.
//
// Contents:
//   state_t          - controller FSM state encoding (IDLE, ACCESS, MERGE, RESP)
//   MEM_SIZE_B/H/W   - access size encodings used on the requester ports
//                      (2'b11 is accepted and behaves as a word access)
//   addr_misaligned  - helper that flags half/word accesses whose byte
//                      address is not naturally aligned
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  // Bytes are always aligned; halves need offset[0]==0; words (and the
  // reserved 2'b11 size) need both offset bits clear.
  function automatic logic addr_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
    logic mis;
    case (size)
      MEM_SIZE_B: mis = 1'b0;
      MEM_SIZE_H: mis = offset[0];
      default:    mis = (offset != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Purely combinational byte-lane logic for the data-memory controller.
//
// Ports:
//   word        in  32  memory word being read or modified
//   offset      in  2   byte offset within the word (addr[1:0])
//   size        in  2   access size (byte / half / word)
//   is_unsigned in  1   zero-extend instead of sign-extend on loads
//   wdata       in  32  right-aligned store data
//   load_data   out 32  selected lane, extended to 32 bits
//   merged      out 32  word with the selected lane replaced by wdata
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Load path: pick the addressed lane, then extend it.
  always_comb begin
    byte_sel  = word[7:0];
    half_sel  = offset[1] ? word[31:16] : word[15:0];
    load_data = word;
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    case (size)
      MEM_SIZE_B: load_data = is_unsigned ? {24'd0, byte_sel}
                                          : {{24{byte_sel[7]}}, byte_sel};
      MEM_SIZE_H: load_data = is_unsigned ? {16'd0, half_sel}
                                          : {{16{half_sel[15]}}, half_sel};
      default:    load_data = word;
    endcase
  end

  // Store path: only the addressed lane changes; a word store replaces all.
  always_comb begin
    merged = word;
    case (size)
      MEM_SIZE_B: begin
        case (offset)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      MEM_SIZE_H: begin
        if (offset[1]) merged[31:16] = wdata[15:0];
        else           merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller for the light RV32I core.
//
// Arbitrates the load/store unit (port 0) and the debug/loader (port 1)
// onto one single-port word-addressed memory, turns byte-addressed
// LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses (sub-word stores
// as registered read-modify-write) and returns one response per request.
//
// Optional feature macro: DMEM_CTRL_RR_EN
//   defined   - round-robin arbitration between the two ports
//   undefined - fixed priority, port 0 always wins
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   i_Req/i_We[1:0]       per-port request (held until granted), store flag
//   i_Addr0/1             byte addresses
//   i_WData0/1            right-aligned store data
//   i_Size0/1             00 byte, 01 half, 10/11 word
//   i_Unsigned[1:0]       zero-extend loads
//   o_Gnt[1:0]            combinational one-hot accept pulse
//   o_RValid[1:0]         one-cycle response pulse to the owning port
//   o_RData               extended load data (0 for stores and errors)
//   o_Err                 misaligned access flag, valid with o_RValid
//   o_MemAddr/WrEn/WData  memory port; i_MemRData is combinational read data
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                i_Req,
  input  logic [1:0]                i_We,
  input  logic [ADDR_WIDTH-1:0]     i_Addr0,
  input  logic [ADDR_WIDTH-1:0]     i_Addr1,
  input  logic [DATA_WIDTH-1:0]     i_WData0,
  input  logic [DATA_WIDTH-1:0]     i_WData1,
  input  logic [1:0]                i_Size0,
  input  logic [1:0]                i_Size1,
  input  logic [1:0]                i_Unsigned,
  output logic [1:0]                o_Gnt,
  output logic [1:0]                o_RValid,
  output logic [DATA_WIDTH-1:0]     o_RData,
  output logic                      o_Err,
  output logic [MEM_ADDR_WIDTH-1:0] o_MemAddr,
  output logic                      o_MemWrEn,
  output logic [DATA_WIDTH-1:0]     o_MemWData,
  input  logic [DATA_WIDTH-1:0]     i_MemRData
);

  // Only the word index plus the byte offset are kept; higher address
  // bits are dropped so accesses wrap around the memory.
  localparam int LAT_AW = MEM_ADDR_WIDTH + 2;

  state_t state_q, state_d;

  logic                  any_req;
  logic                  win_port;
  logic [LAT_AW-1:0]     sel_addr;
  logic                  sel_we;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [1:0]            sel_size;
  logic                  sel_unsigned;
  logic                  sel_misaligned;

  logic                  lat_we;
  logic [LAT_AW-1:0]     lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [1:0]            lat_size;
  logic                  lat_unsigned;
  logic                  lat_port;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] merge_q;

  logic                  lat_word;
  logic [DATA_WIDTH-1:0] align_word;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merged_word;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^{i_Addr0[ADDR_WIDTH-1:LAT_AW], i_Addr1[ADDR_WIDTH-1:LAT_AW]};

`ifdef DMEM_CTRL_RR_EN
  logic rr_ptr;

  // Pointer moves to the port that did not just win, so two ports that
  // request back to back alternate.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (state_q == ST_IDLE && any_req) begin
      rr_ptr <= ~win_port;
    end
  end
`endif

  always_comb begin
    any_req = |i_Req;
`ifdef DMEM_CTRL_RR_EN
    if (&i_Req) win_port = rr_ptr;
    else        win_port = ~i_Req[0];
`else
    win_port = ~i_Req[0];
`endif
  end

  always_comb begin
    sel_addr       = win_port ? i_Addr1[LAT_AW-1:0] : i_Addr0[LAT_AW-1:0];
    sel_we         = i_We[win_port];
    sel_wdata      = win_port ? i_WData1 : i_WData0;
    sel_size       = win_port ? i_Size1 : i_Size0;
    sel_unsigned   = i_Unsigned[win_port];
    sel_misaligned = addr_misaligned(sel_size, sel_addr[1:0]);
  end

  assign lat_word = lat_size[1];

  // MERGE works on the word captured during ACCESS; loads use live data.
  assign align_word = (state_q == ST_MERGE) ? merge_q : i_MemRData;

  dmem_lane_align u_lane_align (
    .word        (align_word),
    .offset      (lat_addr[1:0]),
    .size        (lat_size),
    .is_unsigned (lat_unsigned),
    .wdata       (lat_wdata),
    .load_data   (load_data),
    .merged      (merged_word)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and all combinational outputs. Every output is gated with
  // reset so an interrupted transaction cannot write or respond.
  always_comb begin
    state_d    = state_q;
    o_Gnt      = 2'b00;
    o_RValid   = 2'b00;
    o_Err      = 1'b0;
    o_MemAddr  = '0;
    o_MemWrEn  = 1'b0;
    o_MemWData = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = sel_misaligned ? ST_RESP : ST_ACCESS;
          if (!reset) o_Gnt = win_port ? 2'b10 : 2'b01;
        end
      end
      ST_ACCESS: begin
        o_MemAddr = lat_addr[LAT_AW-1:2];
        if (lat_we && !lat_word) begin
          state_d = ST_MERGE;
        end else begin
          state_d = ST_RESP;
          if (lat_we && !reset) begin
            o_MemWrEn  = 1'b1;
            o_MemWData = lat_wdata;
          end
        end
      end
      ST_MERGE: begin
        state_d   = ST_RESP;
        o_MemAddr = lat_addr[LAT_AW-1:2];
        if (!reset) begin
          o_MemWrEn  = 1'b1;
          o_MemWData = merged_word;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (!reset) begin
          o_RValid = lat_port ? 2'b10 : 2'b01;
          o_Err    = err_q;
        end
      end
    endcase
  end

  // Request capture at grant, load-data / RMW-word capture in ACCESS.
  // o_RData is cleared for store and error responses and otherwise held.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_size     <= MEM_SIZE_B;
      lat_unsigned <= 1'b0;
      lat_port     <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      merge_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            lat_we       <= sel_we;
            lat_addr     <= sel_addr;
            lat_wdata    <= sel_wdata;
            lat_size     <= sel_size;
            lat_unsigned <= sel_unsigned;
            lat_port     <= win_port;
            err_q        <= sel_misaligned;
            if (sel_misaligned) rdata_q <= '0;
          end
        end
        ST_ACCESS: begin
          rdata_q <= lat_we ? '0 : load_data;
          if (lat_we && !lat_word) merge_q <= i_MemRData;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_RData = rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl with a 256-word memory model.
// Follows whichever arbitration mode DMEM_CTRL_RR_EN selects.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  localparam int MAW = 8;

  logic        clk;
  logic        reset;
  logic [1:0]  i_Req, i_We, i_Unsigned;
  logic [31:0] i_Addr0, i_Addr1, i_WData0, i_WData1;
  logic [1:0]  i_Size0, i_Size1;
  logic [1:0]  o_Gnt, o_RValid;
  logic [31:0] o_RData;
  logic        o_Err;
  logic [MAW-1:0] o_MemAddr;
  logic        o_MemWrEn;
  logic [31:0] o_MemWData;
  logic [31:0] i_MemRData;

  logic [31:0] mem [0:(1<<MAW)-1];

  int assertCount = 0;
  int failCount   = 0;

  dmem_ctrl #(.MEM_ADDR_WIDTH(MAW), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .i_Req(i_Req), .i_We(i_We),
    .i_Addr0(i_Addr0), .i_Addr1(i_Addr1), .i_WData0(i_WData0), .i_WData1(i_WData1),
    .i_Size0(i_Size0), .i_Size1(i_Size1), .i_Unsigned(i_Unsigned),
    .o_Gnt(o_Gnt), .o_RValid(o_RValid), .o_RData(o_RData), .o_Err(o_Err),
    .o_MemAddr(o_MemAddr), .o_MemWrEn(o_MemWrEn), .o_MemWData(o_MemWData),
    .i_MemRData(i_MemRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge.
  assign i_MemRData = mem[o_MemAddr];
  always @(posedge clk) begin
    if (o_MemWrEn) mem[o_MemAddr] <= o_MemWData;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Runs one request on a port; returns grant-to-RValid latency in cycles,
  // response data/error and whether a memory write was seen.
  task automatic applyStimulus(input int port, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] size,
                               input logic uns, output int lat, output logic [31:0] rdata,
                               output logic err, output logic sawWrite);
    int cyc;
    logic granted;
    @(negedge clk);
    i_We[port] = we;
    i_Unsigned[port] = uns;
    if (port == 0) begin
      i_Addr0 = addr; i_WData0 = wdata; i_Size0 = size;
    end else begin
      i_Addr1 = addr; i_WData1 = wdata; i_Size1 = size;
    end
    i_Req[port] = 1'b1;
    cyc = 0;
    granted = 1'b0;
    sawWrite = 1'b0;
    lat = 99;
    rdata = '0;
    err = 1'b0;
    while (!granted && cyc < 20) begin
      #1;
      if (o_Gnt[port]) granted = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!granted) begin
      i_Req[port] = 1'b0;
      checkOutput("grantTimeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      i_Req[port] = 1'b0;
      lat = 1;
      while (!o_RValid[port] && lat < 10) begin
        sawWrite |= o_MemWrEn;
        @(negedge clk);
        lat++;
      end
      checkOutput("rvalidVector", {30'd0, o_RValid}, (port == 0) ? 32'd1 : 32'd2);
      rdata = o_RData;
      err = o_Err;
    end
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  logic        sw;
  int          grants [0:4];
  int          nGrant;
  int          cyc;

  initial begin
    for (int i = 0; i < (1<<MAW); i++) mem[i] = 32'd0;
    reset = 1'b1;
    i_Req = 2'b00; i_We = 2'b00; i_Unsigned = 2'b00;
    i_Addr0 = '0; i_Addr1 = '0; i_WData0 = '0; i_WData1 = '0;
    i_Size0 = MEM_SIZE_W; i_Size1 = MEM_SIZE_W;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rstGnt",    {30'd0, o_Gnt}, 32'd0);
    checkOutput("rstRValid", {30'd0, o_RValid}, 32'd0);
    checkOutput("rstWrEn",   {31'd0, o_MemWrEn}, 32'd0);
    checkOutput("rstErr",    {31'd0, o_Err}, 32'd0);
    checkOutput("rstRData",  o_RData, 32'd0);
    checkOutput("rstAddr",   {24'd0, o_MemAddr}, 32'd0);

    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, MEM_SIZE_W, 1'b0, lat, rd, er, sw);
    checkOutput("swLat",   lat, 32'd2);
    checkOutput("swRData", rd, 32'd0);
    checkOutput("swMem",   mem[4], 32'hDEADBEEF);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, MEM_SIZE_W, 1'b0, lat, rd, er, sw);
    checkOutput("lwLat",   lat, 32'd2);
    checkOutput("lwRData", rd, 32'hDEADBEEF);
    checkOutput("lwErr",   {31'd0, er}, 32'd0);

    mem[4] = 32'h11223344;
    applyStimulus(0, 1'b1, 32'h12, 32'h000000AA, MEM_SIZE_B, 1'b0, lat, rd, er, sw);
    checkOutput("sbLat", lat, 32'd3);
    checkOutput("sbMem", mem[4], 32'h11AA3344);
    applyStimulus(0, 1'b0, 32'h12, 32'h0, MEM_SIZE_B, 1'b0, lat, rd, er, sw);
    checkOutput("lbRData", rd, 32'hFFFFFFAA);
    applyStimulus(0, 1'b0, 32'h12, 32'h0, MEM_SIZE_B, 1'b1, lat, rd, er, sw);
    checkOutput("lbuRData", rd, 32'h000000AA);
    applyStimulus(0, 1'b0, 32'h13, 32'h0, MEM_SIZE_B, 1'b0, lat, rd, er, sw);
    checkOutput("lbTopByte", rd, 32'h00000011);
    applyStimulus(0, 1'b0, 32'h12, 32'h0, MEM_SIZE_H, 1'b0, lat, rd, er, sw);
    checkOutput("lhRData", rd, 32'h000011AA);
    applyStimulus(0, 1'b1, 32'h11, 32'h00005555, MEM_SIZE_H, 1'b0, lat, rd, er, sw);
    checkOutput("shMisErr",   {31'd0, er}, 32'd1);
    checkOutput("shMisLat",   lat, 32'd1);
    checkOutput("shMisMem",   mem[4], 32'h11AA3344);
    checkOutput("shMisWrite", {31'd0, sw}, 32'd0);
    checkOutput("shMisRData", rd, 32'd0);
    applyStimulus(0, 1'b0, 32'h12, 32'h0, MEM_SIZE_W, 1'b0, lat, rd, er, sw);
    checkOutput("lwMisErr", {31'd0, er}, 32'd1);
    checkOutput("lwMisLat", lat, 32'd1);

    mem[5] = 32'hCAFEF00D;
    applyStimulus(1, 1'b1, 32'h16, 32'h1234BEEF, MEM_SIZE_H, 1'b0, lat, rd, er, sw);
    checkOutput("p1ShLat", lat, 32'd3);
    checkOutput("p1ShMem", mem[5], 32'hBEEFF00D);
    applyStimulus(1, 1'b0, 32'h16, 32'h0, MEM_SIZE_H, 1'b0, lat, rd, er, sw);
    checkOutput("p1Lh", rd, 32'hFFFFBEEF);
    applyStimulus(1, 1'b0, 32'h16, 32'h0, MEM_SIZE_H, 1'b1, lat, rd, er, sw);
    checkOutput("p1Lhu", rd, 32'h0000BEEF);
    applyStimulus(1, 1'b0, 32'h15, 32'h0, MEM_SIZE_B, 1'b1, lat, rd, er, sw);
    checkOutput("p1Lbu", rd, 32'h000000F0);

    // Size 2'b11 acts as a word; 0x410 wraps onto word 4 of a 256-word memory.
    applyStimulus(0, 1'b0, 32'h410, 32'h0, 2'b11, 1'b0, lat, rd, er, sw);
    checkOutput("wrapLat",   lat, 32'd2);
    checkOutput("wrapRData", rd, 32'h11AA3344);
    @(negedge clk);
    checkOutput("rdataHeld", o_RData, 32'h11AA3344);

    // Reset during MERGE of an SB must drop the write and the response.
    mem[4] = 32'h11223344;
    i_We[0] = 1'b1; i_Addr0 = 32'h12; i_WData0 = 32'h55; i_Size0 = MEM_SIZE_B;
    i_Unsigned[0] = 1'b0;
    i_Req[0] = 1'b1;
    #1;
    checkOutput("rmwGnt", {30'd0, o_Gnt}, 32'd1);
    @(negedge clk);
    i_Req[0] = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("mergeWrEn",  {31'd0, o_MemWrEn}, 32'd1);
    checkOutput("mergeWData", o_MemWData, 32'h11553344);
    reset = 1'b1;
    #1;
    checkOutput("mergeWrEnRst", {31'd0, o_MemWrEn}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("postRstMem",    mem[4], 32'h11223344);
    checkOutput("postRstState",  {30'd0, dut.state_q}, {30'd0, ST_IDLE});
    checkOutput("postRstRValid", {30'd0, o_RValid}, 32'd0);
    checkOutput("postRstWrEn",   {31'd0, o_MemWrEn}, 32'd0);
    checkOutput("postRstErr",    {31'd0, o_Err}, 32'd0);
    checkOutput("postRstRData",  o_RData, 32'd0);
    checkOutput("postRstAddr",   {24'd0, o_MemAddr}, 32'd0);
    checkOutput("postRstGnt",    {30'd0, o_Gnt}, 32'd0);

    // Both ports request continuously; record the first four winners.
    i_We = 2'b00; i_Unsigned = 2'b00;
    i_Addr0 = 32'h10; i_Addr1 = 32'h14;
    i_Size0 = MEM_SIZE_W; i_Size1 = MEM_SIZE_W;
    i_Req = 2'b11;
    nGrant = 0;
    cyc = 0;
    while (nGrant < 4 && cyc < 60) begin
      #1;
      if (o_Gnt != 2'b00) begin
        grants[nGrant] = o_Gnt[1] ? 1 : 0;
        checkOutput("gntOneHot", {31'd0, $onehot(o_Gnt)}, 32'd1);
        nGrant++;
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput("arbCount", nGrant, 32'd4);
    for (int i = 0; i < nGrant; i++) begin
`ifdef DMEM_CTRL_RR_EN
      checkOutput("arbOrder", grants[i], i % 2);
`else
      checkOutput("arbOrder", grants[i], 32'd0);
`endif
    end
    // Port 1 gets in once port 0 stops asking.
    i_Req[0] = 1'b0;
    nGrant = 0;
    cyc = 0;
    while (nGrant == 0 && cyc < 20) begin
      #1;
      if (o_Gnt != 2'b00) begin
        grants[4] = o_Gnt[1] ? 1 : 0;
        nGrant = 1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput("p1Served", nGrant, 32'd1);
    if (nGrant == 1) checkOutput("p1Winner", grants[4], 32'd1);
    @(negedge clk);
    i_Req = 2'b00;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Controller in front of the single-port word-addressed data memory of the light RV32I core.
- Arbitrates two requesters onto the one memory port: port 0 is the core load/store unit, port 1 is the debug/loader.
- Converts byte addresses and LB/LH/LW/LBU/LHU/SB/SH/SW semantics into word accesses. Sub-word stores are done as registered read-modify-write.
- Returns one registered response per request.

Parameters:
- MEM_ADDR_WIDTH, `_MEM_ADDR_WIDTH_, word-address width of the memory port
- DATA_WIDTH, `_DATA_WIDTH_, word width; only 32 is supported
- ADDR_WIDTH, 32, byte-address width on the requester ports

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_Req[1:0]  in  2  request per port, held until granted
- i_We[1:0]  in  2  1 = store, 0 = load
- i_Addr0, i_Addr1  in  ADDR_WIDTH each  byte address
- i_WData0, i_WData1  in  DATA_WIDTH each  store data, right-aligned
- i_Size0, i_Size1  in  2 each  00 byte, 01 half, 10 word; 11 is treated as word
- i_Unsigned[1:0]  in  2  zero-extend loads
- o_Gnt[1:0]  out  2  one-hot, combinational, 1-cycle accept pulse
- o_RValid[1:0]  out  2  one-cycle response pulse to the owning port
- o_RData  out  DATA_WIDTH  extended load data; 0 for stores
- o_Err  out  1  misaligned access, valid with o_RValid
- o_MemAddr  out  MEM_ADDR_WIDTH  word address to memory
- o_MemWrEn  out  1  memory write enable
- o_MemWData  out  DATA_WIDTH  memory write data
- i_MemRData  in  DATA_WIDTH  combinational memory read data

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high, port names clk and reset.
- Reset values: state=IDLE; o_Gnt, o_RValid, o_MemWrEn, o_Err = 0; o_RData = 0; o_MemAddr = 0; round-robin pointer = port 0.
- Reset mid-operation abandons the transaction. No write is issued in the reset cycle or after it, and no response is sent.
- States: IDLE, ACCESS, MERGE, RESP.
- IDLE:
  - If any i_Req is high, o_Gnt pulses for the winner and the controller latches we, addr, wdata, size, unsigned and the port id.
  - Next state is ACCESS, or RESP if misaligned.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0. It makes no memory access and sets err=1.
- ACCESS: o_MemAddr = latched addr[MEM_ADDR_WIDTH+1:2]; upper address bits are ignored, so addresses wrap.
  - Load: extract the byte/half selected by addr[1:0], sign- or zero-extend it, register it into o_RData, then go to RESP.
  - Word store: o_MemWrEn=1 with o_MemWData=wdata, then go to RESP.
  - Sub-word store: register i_MemRData, then go to MERGE.
- MERGE:
  - Same address as ACCESS; o_MemWrEn=1.
  - Write data is the registered word with the target byte/half lane replaced by wdata[7:0] or wdata[15:0].
  - Next state is RESP.
- RESP: o_RValid[port]=1 for one cycle, o_Err=err, then IDLE.
- Latency from the grant cycle to o_RValid:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - misaligned: 1 cycle
- o_Gnt is 0 outside IDLE; requests wait.
- o_MemWrEn is asserted only in ACCESS (word store) and MERGE.
- o_RData is held until the next load response. It is 0 on store and error responses.

Optional Feature:
- Macro DMEM_CTRL_RR_EN.
- Defined: round-robin arbitration. The pointer toggles to the other port after each grant; on simultaneous requests the port the pointer selects wins.
- Undefined: fixed priority, port 0 always wins, and the pointer logic is absent.

Decomposition:
- Add to the shared light_rv32i_defs.vh:
  - size encodings: `_MEM_SIZE_B_, `_MEM_SIZE_H_, `_MEM_SIZE_W_
  - FSM state encodings
- One natural sub-module: dmem_lane_align, purely combinational. It provides:
  - load lane extraction plus sign/zero extension
  - store lane merge

Test Plan:
- SW port0 addr 0x10, data 0xDEADBEEF, then LW 0x10 → word 4 written; RData=0xDEADBEEF two cycles after grant.
- Word 4 = 0x11223344; SB port0 addr 0x12 data 0xAA → word 4 = 0x11AA3344 after MERGE; RValid three cycles after grant. Then LB 0x12 → 0xFFFFFFAA; LBU → 0x000000AA.
- Word 4 = 0x11AA3344; LH 0x12 → 0x000011AA; SH 0x11 → Err=1, RValid one cycle after grant, word 4 unchanged, MemWrEn never high.
- Both ports request every cycle for 4 transactions:
  - with DMEM_CTRL_RR_EN, grants go 0,1,0,1
  - without it, grants go 0,0,0,0 and port 1 waits until port 0 drops its request
- Reset asserted in the MERGE cycle of an SB → no write (target word unchanged), no RValid, state IDLE, all outputs 0 next cycle.
